grid_rmw_combinator: RTL

- Pipelined read-modify-write accumulator for the gridding datapath.
- Takes one adder result per transaction: PARALLELISM complex samples plus a grid address. Reads the two-line BRAM window at that address, adds the samples into the lanes at the given lane offset, and writes the window back.
- Generalises the combinational lane merge into a sequential block with a parametrised read latency, accumulate/overwrite modes, saturation, and address-hazard stalling.
- Sits between the adder tree and the double-wide grid BRAM.

---
 rtl/grid_rmw_combinator.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/grid_rmw_combinator.sv
// Pipelined read-modify-write accumulator between the adder tree and the double-wide grid BRAM.
// Reads a two-line window, merges PARALLELISM samples at a lane offset, and writes the window back.
module grid_rmw_combinator #(
   parameter int PRECISION             = 32,
   parameter int COMPLEX               = 2,
   parameter int PARALLELISM           = 15,
   parameter int BRAM_PARALLELISM_BITS = 4,
   parameter int BRAM_DEPTH_BITS       = 10,
   parameter int RD_LAT                = 2,
   parameter int SATURATE              = 1,
   localparam int BRAM_PARALLELISM     = 2**BRAM_PARALLELISM_BITS,
   localparam int DATA_WIDTH           = PRECISION*COMPLEX,
   localparam int DATA_PATH_WIDTH      = PARALLELISM*DATA_WIDTH,
   localparam int BRAM_WIDTH           = BRAM_PARALLELISM*DATA_WIDTH,
   localparam int ADDR_WIDTH           = BRAM_DEPTH_BITS+BRAM_PARALLELISM_BITS
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ADDR_WIDTH-1:0]        in_addr,
   input  logic                         in_mode,
   input  logic [DATA_PATH_WIDTH-1:0]   in_data,
   output logic                         mem_rd_en,
   output logic [BRAM_DEPTH_BITS-1:0]   mem_rd_addr,
   input  logic [2*BRAM_WIDTH-1:0]      mem_rd_data,
   output logic                         mem_wr_en,
   output logic [BRAM_DEPTH_BITS-1:0]   mem_wr_addr,
   output logic [2*BRAM_WIDTH-1:0]      mem_wr_data,
   output logic                         sat_flag,
   input  logic                         sat_clr,
   output logic                         busy
);

   localparam int NSTG   = RD_LAT+1;
   localparam int LAST   = RD_LAT;
   localparam int NLANES = 2*BRAM_PARALLELISM;

   logic [BRAM_DEPTH_BITS-1:0]       inLine;
   logic [BRAM_PARALLELISM_BITS-1:0] inOff;
   logic                             hazard;
   logic                             accept;

   logic [NSTG-1:0]                  stgValid;
   logic [BRAM_DEPTH_BITS-1:0]       stgLine [NSTG];
   logic [BRAM_PARALLELISM_BITS-1:0] stgOff  [NSTG];
   logic [NSTG-1:0]                  stgMode;
   logic [DATA_PATH_WIDTH-1:0]       stgData [NSTG];

   logic [2*BRAM_WIDTH-1:0]          merged;
   logic                             satHit;
   int                               laneIdx;
   logic [DATA_WIDTH-1:0]            sample;
   logic [DATA_WIDTH-1:0]            oldLane;
   logic [PRECISION-1:0]             opA;
   logic [PRECISION-1:0]             opB;
   logic [PRECISION:0]               sum;

   assign {inLine, inOff} = in_addr;

   // Two windows collide when their base lines are within one line of each other, modulo depth.
   function automatic logic lineNear(input logic [BRAM_DEPTH_BITS-1:0] a,
                                     input logic [BRAM_DEPTH_BITS-1:0] b);
      logic [BRAM_DEPTH_BITS-1:0] d;
      d = a - b;
      return (d == '0) || (d == BRAM_DEPTH_BITS'(1)) || (d == '1);
   endfunction

   // Hold off any request whose window overlaps a transaction still in flight, write cycle included.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < NSTG; i++) begin
         if (stgValid[i] && lineNear(inLine, stgLine[i])) hazard = 1'b1;
      end
      if (mem_wr_en && lineNear(inLine, mem_wr_addr)) hazard = 1'b1;
   end

   assign in_ready = !(in_valid && hazard);
   assign accept   = in_valid && in_ready;

   // Lane merge on the returned window; saturation clamps on signed overflow of each component.
   always_comb begin
      merged  = mem_rd_data;
      satHit  = 1'b0;
      laneIdx = 0;
      sample  = '0;
      oldLane = '0;
      opA     = '0;
      opB     = '0;
      sum     = '0;
      for (int k = 0; k < NLANES; k++) begin
         laneIdx = k - int'(stgOff[LAST]);
         if (laneIdx >= 0 && laneIdx < PARALLELISM) begin
            sample  = stgData[LAST][laneIdx*DATA_WIDTH +: DATA_WIDTH];
            oldLane = mem_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
            if (stgMode[LAST]) begin
               merged[k*DATA_WIDTH +: DATA_WIDTH] = sample;
            end else begin
               for (int c = 0; c < COMPLEX; c++) begin
                  opA = oldLane[c*PRECISION +: PRECISION];
                  opB = sample[c*PRECISION +: PRECISION];
                  sum = {opA[PRECISION-1], opA} + {opB[PRECISION-1], opB};
                  if (SATURATE != 0 && sum[PRECISION] != sum[PRECISION-1]) begin
                     merged[k*DATA_WIDTH + c*PRECISION +: PRECISION] =
                        {sum[PRECISION], {(PRECISION-1){~sum[PRECISION]}}};
                     satHit = 1'b1;
                  end else begin
                     merged[k*DATA_WIDTH + c*PRECISION +: PRECISION] = sum[PRECISION-1:0];
                  end
               end
            end
         end
      end
   end

   // Control pipeline: valids, line addresses, write port and sticky saturation flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stgValid    <= '0;
         for (int i = 0; i < NSTG; i++) stgLine[i] <= '0;
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         sat_flag    <= 1'b0;
      end else begin
         stgValid <= {stgValid[NSTG-2:0], accept};
         if (accept) stgLine[0] <= inLine;
         for (int i = 1; i < NSTG; i++) stgLine[i] <= stgLine[i-1];
         mem_wr_en <= stgValid[LAST];
         if (stgValid[LAST]) begin
            mem_wr_addr <= stgLine[LAST];
            mem_wr_data <= merged;
         end
         sat_flag <= (sat_flag && !sat_clr) || (stgValid[LAST] && satHit);
      end
   end

   // Payload travels alongside the valids; it is only consumed when its valid is set.
   always_ff @(posedge clk) begin
      if (accept) begin
         stgOff[0]  <= inOff;
         stgMode[0] <= in_mode;
         stgData[0] <= in_data;
      end
      for (int i = 1; i < NSTG; i++) begin
         stgOff[i]  <= stgOff[i-1];
         stgMode[i] <= stgMode[i-1];
         stgData[i] <= stgData[i-1];
      end
   end

   assign mem_rd_en   = stgValid[0];
   assign mem_rd_addr = stgLine[0];
   assign busy        = (|stgValid) || mem_wr_en;

endmodule
